// File: rtl/ariane_pkg.sv
// Shared core definitions used by the divider and its issue controller.
//   TRANS_ID_BITS : width of the scoreboard transaction ID
//   OP_*          : 2-bit divide opcode encoding shared with the serial divider
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

    localparam logic [1:0] OP_UDIV = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_UREM = 2'd2;
    localparam logic [1:0] OP_REM  = 2'd3;

endpackage

// File: rtl/div_issue_ctrl_pkg.sv
// Local types for div_issue_ctrl: FSM state encoding and field widths.
// DIV_ISSUE_CTRL_RESULT_BUF_EN adds the WB state used by the result buffer.
package div_issue_ctrl_pkg;

    localparam int unsigned OPCODE_BITS = 2;
    localparam int unsigned STATE_BITS  = 2;

    typedef enum logic [STATE_BITS-1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2
`ifdef DIV_ISSUE_CTRL_RESULT_BUF_EN
        ,
        WB       = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Serial-divider handshake bundle between the issue controller (master)
// and the divider (slave).
//   in_vld/in_rdy        : request handshake
//   req_id/op_a/op_b/opcode : request payload
//   flush                : abort forwarded to the divider
//   out_vld/out_rdy      : result handshake
//   res_id/res           : result payload
interface div_issue_ctrl_if #(
    parameter int unsigned WIDTH = 64
) ();

    logic                                  in_vld;
    logic                                  in_rdy;
    logic [ariane_pkg::TRANS_ID_BITS-1:0]  req_id;
    logic [WIDTH-1:0]                      op_a;
    logic [WIDTH-1:0]                      op_b;
    logic [1:0]                            opcode;
    logic                                  flush;
    logic                                  out_vld;
    logic                                  out_rdy;
    logic [ariane_pkg::TRANS_ID_BITS-1:0]  res_id;
    logic [WIDTH-1:0]                      res;

    modport master (
        output in_vld, req_id, op_a, op_b, opcode, flush, out_rdy,
        input  in_rdy, out_vld, res_id, res
    );

    modport slave (
        input  in_vld, req_id, op_a, op_b, opcode, flush, out_rdy,
        output in_rdy, out_vld, res_id, res
    );

endinterface

// File: rtl/div_issue_ctrl.sv
// Initiator side of the serial-divider handshake. Registers one divide
// request from issue, presents it to the divider one cycle after the divider
// signals ready, and returns the result with its ID to writeback.
// Optional feature macro: DIV_ISSUE_CTRL_RESULT_BUF_EN (registered result
// buffer, divider released independently of writeback).
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   flush_i              : abort in-flight work (forwarded on div.flush)
//   req_*                : issue request (valid/ready, ID, operands, opcode)
//   div                  : divider handshake bundle (master modport)
//   wb_*                 : writeback result (valid/ready, ID, result)
//   busy_o               : FSM not idle
module div_issue_ctrl
    import ariane_pkg::*;
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [TRANS_ID_BITS-1:0] req_id_i,
    input  logic [WIDTH-1:0]         req_op_a_i,
    input  logic [WIDTH-1:0]         req_op_b_i,
    input  logic [OPCODE_BITS-1:0]   req_opcode_i,
    div_issue_ctrl_if.master         div,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [TRANS_ID_BITS-1:0] wb_id_o,
    output logic [WIDTH-1:0]         wb_result_o,
    output logic                     busy_o
);

    state_e                   state_q, state_d;
    logic                     rdy_q;
    logic                     load_req;
    logic [TRANS_ID_BITS-1:0] id_q;
    logic [WIDTH-1:0]         op_a_q;
    logic [WIDTH-1:0]         op_b_q;
    logic [OPCODE_BITS-1:0]   opcode_q;

`ifdef DIV_ISSUE_CTRL_RESULT_BUF_EN
    logic                     load_res;
    logic [TRANS_ID_BITS-1:0] res_id_q;
    logic [WIDTH-1:0]         res_q;
`endif

    // State, registered divider ready, and request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= div.in_rdy;
            if (load_req) begin
                id_q     <= req_id_i;
                op_a_q   <= req_op_a_i;
                op_b_q   <= req_op_b_i;
                opcode_q <= req_opcode_i;
            end
        end
    end

`ifdef DIV_ISSUE_CTRL_RESULT_BUF_EN
    // Result buffer: decouples divider release from writeback stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_id_q <= '0;
            res_q    <= '0;
        end else if (load_res) begin
            res_id_q <= div.res_id;
            res_q    <= div.res;
        end
    end
`endif

    // Next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        load_req    = 1'b0;
        req_ready_o = 1'b0;
        div.in_vld  = 1'b0;
        div.out_rdy = 1'b0;
        wb_valid_o  = 1'b0;
`ifdef DIV_ISSUE_CTRL_RESULT_BUF_EN
        load_res    = 1'b0;
        wb_id_o     = res_id_q;
        wb_result_o = res_q;
`else
        wb_id_o     = div.res_id;
        wb_result_o = div.res;
`endif

        unique case (state_q)
            IDLE: begin
                req_ready_o = ~flush_i;
                if (req_valid_i && !flush_i) begin
                    load_req = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // rdy_q gives the divider's required one-cycle rdy->vld gap
                div.in_vld = rdy_q & ~flush_i;
                if (rdy_q && !flush_i) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
`ifdef DIV_ISSUE_CTRL_RESULT_BUF_EN
                div.out_rdy = 1'b1;
                if (div.out_vld && !flush_i) begin
                    load_res = 1'b1;
                    state_d  = WB;
                end
`else
                div.out_rdy = wb_ready_i;
                wb_valid_o  = div.out_vld & ~flush_i;
                if (div.out_vld && wb_ready_i) begin
                    state_d = IDLE;
                end
`endif
            end
`ifdef DIV_ISSUE_CTRL_RESULT_BUF_EN
            WB: begin
                wb_valid_o = ~flush_i;
                if (wb_ready_i) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    assign div.req_id = id_q;
    assign div.op_a   = op_a_q;
    assign div.op_b   = op_b_q;
    assign div.opcode = opcode_q;
    assign div.flush  = flush_i;
    assign busy_o     = (state_q != IDLE);

`ifndef SYNTHESIS
    // A result carrying a foreign ID means the divider broke protocol
    result_id_matches: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == WAIT_RES && div.out_vld && !flush_i) |-> (div.res_id == id_q))
        else $error("div_issue_ctrl: result ID does not match issued ID");
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed testbench for div_issue_ctrl; plays the divider and writeback
// roles and checks handshake timing and payloads in either buffer build.
module tb_div_issue_ctrl;
    import ariane_pkg::*;

    localparam int unsigned WIDTH = 64;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic                     req_valid;
    logic                     req_ready;
    logic [TRANS_ID_BITS-1:0] req_id;
    logic [WIDTH-1:0]         op_a;
    logic [WIDTH-1:0]         op_b;
    logic [1:0]               opcode;
    logic                     wb_valid;
    logic                     wb_ready;
    logic [TRANS_ID_BITS-1:0] wb_id;
    logic [WIDTH-1:0]         wb_result;
    logic                     busy;

    int n_vec = 0;
    int n_err = 0;

    div_issue_ctrl_if #(.WIDTH(WIDTH)) dif ();

    div_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_id_i     (req_id),
        .req_op_a_i   (op_a),
        .req_op_b_i   (op_b),
        .req_opcode_i (opcode),
        .div          (dif.master),
        .wb_valid_o   (wb_valid),
        .wb_ready_i   (wb_ready),
        .wb_id_o      (wb_id),
        .wb_result_o  (wb_result),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_in_vld"},    64'(dif.in_vld), 64'd0);
        check({tag, "_out_rdy"},   64'(dif.out_rdy), 64'd0);
        check({tag, "_wb_valid"},  64'(wb_valid), 64'd0);
        check({tag, "_busy"},      64'(busy), 64'd0);
        check({tag, "_op_a"},      dif.op_a, 64'd0);
        check({tag, "_id"},        64'(dif.req_id), 64'd0);
    endtask

    // Present one request in IDLE; leaves the bench one cycle later (+3)
    task automatic issue_req(input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] a,
                             input logic [63:0] b, input logic [1:0] op);
        req_valid = 1'b1;
        req_id    = id;
        op_a      = a;
        op_b      = b;
        opcode    = op;
        settle();
        check("accept_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        op_a      = '0;
        op_b      = '0;
        settle();
    endtask

    // In the cycle in_vld is due: check payload, then that it lasts one cycle
    task automatic expect_issue(input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] a,
                                input logic [63:0] b, input logic [1:0] op);
        check("issue_vld",    64'(dif.in_vld), 64'd1);
        check("issue_op_a",   dif.op_a, a);
        check("issue_op_b",   dif.op_b, b);
        check("issue_id",     64'(dif.req_id), 64'(id));
        check("issue_opcode", 64'(dif.opcode), 64'(op));
        tick();
        settle();
        check("issue_once",   64'(dif.in_vld), 64'd0);
        check("issue_busy",   64'(busy), 64'd1);
    endtask

    // Divider returns a result with writeback ready; ends back in IDLE
    task automatic return_res(input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] r);
        dif.out_vld = 1'b1;
        dif.res_id  = id;
        dif.res     = r;
        wb_ready    = 1'b1;
        settle();
        check("res_out_rdy", 64'(dif.out_rdy), 64'd1);
`ifdef DIV_ISSUE_CTRL_RESULT_BUF_EN
        check("res_wb_early", 64'(wb_valid), 64'd0);
        tick();
        dif.out_vld = 1'b0;
        settle();
`endif
        check("wb_valid",  64'(wb_valid), 64'd1);
        check("wb_id",     64'(wb_id), 64'(id));
        check("wb_result", wb_result, r);
        tick();
        dif.out_vld = 1'b0;
        settle();
        check("done_busy", 64'(busy), 64'd0);
        check("done_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        req_valid   = 1'b0;
        req_id      = '0;
        op_a        = '0;
        op_b        = '0;
        opcode      = '0;
        wb_ready    = 1'b1;
        dif.in_rdy  = 1'b1;
        dif.out_vld = 1'b0;
        dif.res_id  = '0;
        dif.res     = '0;
        #3;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic issue: 100/7 udiv, ID 3, divider always ready
        issue_req(3'd3, 64'd100, 64'd7, OP_UDIV);
        expect_issue(3'd3, 64'd100, 64'd7, OP_UDIV);
        return_res(3'd3, 64'd14);

        // Divider not ready at accept and for four cycles after
        dif.in_rdy = 1'b0;
        issue_req(3'd1, 64'd50, 64'd5, OP_DIV);
        for (int i = 0; i < 4; i++) begin
            check("nrdy_vld",  64'(dif.in_vld), 64'd0);
            check("nrdy_op_a", dif.op_a, 64'd50);
            check("nrdy_op_b", dif.op_b, 64'd5);
            tick();
            settle();
        end
        dif.in_rdy = 1'b1;
        settle();
        check("nrdy_gap", 64'(dif.in_vld), 64'd0);
        tick();
        settle();
        expect_issue(3'd1, 64'd50, 64'd5, OP_DIV);
        return_res(3'd1, 64'd10);

        // Writeback backpressure for five cycles: 200 urem 9 = 2
        issue_req(3'd2, 64'd200, 64'd9, OP_UREM);
        expect_issue(3'd2, 64'd200, 64'd9, OP_UREM);
        dif.out_vld = 1'b1;
        dif.res_id  = 3'd2;
        dif.res     = 64'd2;
        wb_ready    = 1'b0;
        settle();
`ifdef DIV_ISSUE_CTRL_RESULT_BUF_EN
        check("bp_out_rdy_buf", 64'(dif.out_rdy), 64'd1);
        tick();
        dif.out_vld = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            check("bp_wb_valid", 64'(wb_valid), 64'd1);
            check("bp_wb_res",   wb_result, 64'd2);
            check("bp_out_rdy",  64'(dif.out_rdy), 64'd0);
            tick();
            settle();
        end
`else
        for (int i = 0; i < 5; i++) begin
            check("bp_out_rdy",  64'(dif.out_rdy), 64'd0);
            check("bp_wb_valid", 64'(wb_valid), 64'd1);
            check("bp_wb_res",   wb_result, 64'd2);
            check("bp_busy",     64'(busy), 64'd1);
            tick();
            settle();
        end
`endif
        wb_ready = 1'b1;
        settle();
        check("bp_release_valid", 64'(wb_valid), 64'd1);
        check("bp_release_id",    64'(wb_id), 64'd2);
        tick();
        dif.out_vld = 1'b0;
        settle();
        check("bp_done_busy", 64'(busy), 64'd0);

        // Flush in WAIT_RES, then a stale result arrives and must be ignored
        issue_req(3'd4, 64'd77, 64'd3, OP_REM);
        expect_issue(3'd4, 64'd77, 64'd3, OP_REM);
        flush = 1'b1;
        settle();
        check("flush_fwd",      64'(dif.flush), 64'd1);
        check("flush_wb_valid", 64'(wb_valid), 64'd0);
        tick();
        flush = 1'b0;
        settle();
        check("flush_busy", 64'(busy), 64'd0);
        dif.out_vld = 1'b1;
        dif.res_id  = 3'd4;
        dif.res     = 64'd2;
        settle();
        check("stale_wb_valid", 64'(wb_valid), 64'd0);
        check("stale_out_rdy",  64'(dif.out_rdy), 64'd0);
        tick();
        dif.out_vld = 1'b0;
        settle();
        check("stale_busy", 64'(busy), 64'd0);
        issue_req(3'd5, 64'd81, 64'd9, OP_UDIV);
        expect_issue(3'd5, 64'd81, 64'd9, OP_UDIV);
        return_res(3'd5, 64'd9);

        // Flush in ISSUE with divider ready suppresses in_vld
        issue_req(3'd6, 64'd12, 64'd4, OP_DIV);
        flush = 1'b1;
        settle();
        check("flush_issue_vld", 64'(dif.in_vld), 64'd0);
        tick();
        flush = 1'b0;
        settle();
        check("flush_issue_busy", 64'(busy), 64'd0);

        // Flush together with a request in IDLE
        flush     = 1'b1;
        req_valid = 1'b1;
        req_id    = 3'd7;
        settle();
        check("flushreq_ready", 64'(req_ready), 64'd0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        settle();
        check("flushreq_busy", 64'(busy), 64'd0);
        tick();
        settle();
        check("flushreq_no_vld", 64'(dif.in_vld), 64'd0);

        // Reset asserted mid-ISSUE clears everything immediately
        dif.in_rdy = 1'b0;
        issue_req(3'd6, 64'd99, 64'd11, OP_UREM);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        settle();
        check_reset_outputs("midrst");
        tick();
        rst_n      = 1'b1;
        dif.in_rdy = 1'b1;
        tick();
        settle();
        issue_req(3'd2, 64'd9, 64'd2, OP_REM);
        expect_issue(3'd2, 64'd9, 64'd2, OP_REM);
        return_res(3'd2, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
